// File: rtl/crg_pkg.sv
// ---------------------------------------------------------------------------
// crg_pkg
// Shared definitions for the reset sequencer behind the clock/reset PLL:
//   - crg_state_e   : sequencer states
//   - RETRY_W       : width of the saturating lock-timeout counter
//   - crg_cnt_width : width of the single phase counter shared by all states
// ---------------------------------------------------------------------------
package crg_pkg;

    localparam int RETRY_W = 8;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        FILTER    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } crg_state_e;

    // The states never overlap in time, so one counter serves every interval;
    // it has to hold the largest terminal value, with one bit of headroom.
    function automatic int crg_cnt_width(input int a, input int b,
                                         input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/crg_sync2.sv
// ---------------------------------------------------------------------------
// crg_sync2
// Two-flop synchroniser for a single asynchronous level.
// Ports:
//   clk   in  sampling clock
//   reset in  asynchronous active-high reset, clears both flops to 0
//   i_d   in  asynchronous input level
//   o_q   out synchronised level, two clk edges behind i_d
// ---------------------------------------------------------------------------
module crg_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_d};
        end
    end

    assign o_q = r_sync[1];

endmodule

// File: rtl/crg_reset_seq.sv
// ---------------------------------------------------------------------------
// crg_reset_seq
// Reset sequencer sitting behind the PLL: pulses the PLL reset, waits for a
// filtered lock, then releases N_OUT reset domains one at a time (bit 0
// first). Lock loss re-asserts every domain; a lock that never arrives
// retries the PLL after LOCK_TIMEOUT cycles.
// Ports:
//   clk        in   sequencer clock (free running)
//   reset      in   asynchronous active-high reset
//   pll_locked in   PLL lock, asynchronous to clk
//   sw_reset   in   synchronous restart request (level)
//   pll_reset  out  active-high reset to the PLL
//   rst_out    out  N_OUT active-high domain resets
//   ready      out  every domain released
//   lock_lost  out  sticky: lock dropped after release began
//   retry_cnt  out  saturating count of lock timeouts
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module crg_reset_seq
    import crg_pkg::*;
#(
    parameter int N_OUT        = 4,
    parameter int LOCK_FILT    = 1024,
    parameter int STAGE_GAP    = 16,
    parameter int PLL_RST_LEN  = 8,
    parameter int LOCK_TIMEOUT = 65536
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pll_locked,
    input  logic               sw_reset,
    output logic               pll_reset,
    output logic [N_OUT-1:0]   rst_out,
    output logic               ready,
    output logic               lock_lost,
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam int CNT_W   = crg_cnt_width(LOCK_FILT, STAGE_GAP, PLL_RST_LEN, LOCK_TIMEOUT);
    localparam int STAGE_W = $clog2(N_OUT) + 1;

    localparam logic [CNT_W-1:0]   PLL_LAST     = CNT_W'(PLL_RST_LEN - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   GAP_LAST     = CNT_W'(STAGE_GAP - 1);
    // The WAIT_LOCK cycle that first sees lock is the first filter sample,
    // so FILTER itself only has to see LOCK_FILT-1 more.
    localparam logic [CNT_W-1:0]   FILT_LAST    = CNT_W'((LOCK_FILT >= 2) ? LOCK_FILT - 2 : 0);
    localparam logic [STAGE_W-1:0] LAST_STAGE   = STAGE_W'(N_OUT - 1);

    crg_state_e         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [STAGE_W-1:0] r_stage;
    logic [N_OUT-1:0]   r_rst_out;
    logic               r_ready;
    logic               r_pll_reset;
    logic               r_lock_lost;
    logic [RETRY_W-1:0] r_retry;

    crg_state_e         w_state;
    logic [CNT_W-1:0]   w_cnt;
    logic [STAGE_W-1:0] w_stage;
    logic [N_OUT-1:0]   w_rst_out;
    logic               w_ready;
    logic               w_pll_reset;
    logic               w_lock_lost;
    logic [RETRY_W-1:0] w_retry;
    logic               w_locked_s;
    logic               w_start_rel;
    logic               w_drop;

    crg_sync2 u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (pll_locked),
        .o_q   (w_locked_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= PLL_RST;
            r_cnt       <= '0;
            r_stage     <= '0;
            r_rst_out   <= '1;
            r_ready     <= 1'b0;
            r_pll_reset <= 1'b1;
            r_lock_lost <= 1'b0;
            r_retry     <= '0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_stage     <= w_stage;
            r_rst_out   <= w_rst_out;
            r_ready     <= w_ready;
            r_pll_reset <= w_pll_reset;
            r_lock_lost <= w_lock_lost;
            r_retry     <= w_retry;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_stage     = r_stage;
        w_rst_out   = r_rst_out;
        w_ready     = r_ready;
        w_pll_reset = r_pll_reset;
        w_lock_lost = r_lock_lost;
        w_retry     = r_retry;
        w_start_rel = 1'b0;
        w_drop      = 1'b0;

        case (r_state)
            PLL_RST: begin
                if (r_cnt == PLL_LAST) begin
                    w_state     = WAIT_LOCK;
                    w_cnt       = '0;
                    w_pll_reset = 1'b0;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            WAIT_LOCK: begin
                if (w_locked_s) begin
                    if (LOCK_FILT == 1) begin
                        w_start_rel = 1'b1;
                    end else begin
                        w_state = FILTER;
                        w_cnt   = '0;
                    end
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_state     = PLL_RST;
                    w_cnt       = '0;
                    w_pll_reset = 1'b1;
                    if (r_retry != '1) begin
                        w_retry = r_retry + RETRY_W'(1);
                    end
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            FILTER: begin
                if (!w_locked_s) begin
                    w_state = WAIT_LOCK;
                    w_cnt   = '0;
                end else if (r_cnt == FILT_LAST) begin
                    w_start_rel = 1'b1;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            RELEASE: begin
                if (!w_locked_s) begin
                    w_drop = 1'b1;
                end else if (r_cnt == GAP_LAST) begin
                    // Thermometer shift: one more low bit released per stage.
                    w_rst_out = r_rst_out << 1;
                    w_cnt     = '0;
                    w_stage   = r_stage + STAGE_W'(1);
                    if (r_stage == LAST_STAGE) begin
                        w_ready = 1'b1;
                        w_state = RUN;
                    end
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            RUN: begin
                if (!w_locked_s) begin
                    w_drop = 1'b1;
                end
            end
            default: begin
                w_state = PLL_RST;
            end
        endcase

        // First domain leaves reset on the edge the filter completes.
        if (w_start_rel) begin
            w_rst_out = r_rst_out << 1;
            w_stage   = STAGE_W'(1);
            w_cnt     = '0;
            if (N_OUT == 1) begin
                w_ready = 1'b1;
                w_state = RUN;
            end else begin
                w_state = RELEASE;
            end
        end

        // Lock loss after release began: every domain back into reset, but the
        // PLL is left alone; the WAIT_LOCK timeout decides whether to retry it.
        if (w_drop) begin
            w_state     = WAIT_LOCK;
            w_cnt       = '0;
            w_stage     = '0;
            w_rst_out   = '1;
            w_ready     = 1'b0;
            w_lock_lost = 1'b1;
        end

        // Software restart overrides lock loss and timeout in the same cycle.
        if (sw_reset) begin
            w_state     = PLL_RST;
            w_cnt       = '0;
            w_stage     = '0;
            w_rst_out   = '1;
            w_ready     = 1'b0;
            w_pll_reset = 1'b1;
            w_lock_lost = 1'b0;
            w_retry     = '0;
        end
    end

    assign pll_reset = r_pll_reset;
    assign rst_out   = r_rst_out;
    assign ready     = r_ready;
    assign lock_lost = r_lock_lost;
    assign retry_cnt = r_retry;

endmodule

// File: tb/tb_crg_reset_seq.sv
// ---------------------------------------------------------------------------
// tb_crg_reset_seq
// Drives the reset sequencer through bring-up, a filter glitch, lock loss in
// RUN, software restart mid-release, a long no-lock period that saturates
// the retry counter, an asynchronous reset mid-release and a random phase.
// Each stimulus cycle advances a timestamp-based reference model and queues
// the expected outputs; a separate monitor pops and compares one entry per
// clock edge.
// ---------------------------------------------------------------------------
module tb_crg_reset_seq;

    localparam int N_OUT        = 4;
    localparam int LOCK_FILT    = 16;
    localparam int STAGE_GAP    = 4;
    localparam int PLL_RST_LEN  = 8;
    localparam int LOCK_TIMEOUT = 64;

    // Model phases: PLL held in reset, acquiring lock, domains released.
    localparam int M_PLLRST   = 0;
    localparam int M_ACQUIRE  = 1;
    localparam int M_RELEASED = 2;

    typedef struct packed {
        logic             pllReset;
        logic [N_OUT-1:0] rstOut;
        logic             ready;
        logic             lockLost;
        logic [7:0]       retry;
    } outVec_t;

    logic             clk;
    logic             reset;
    logic             pllLocked;
    logic             swReset;
    logic             pllReset;
    logic [N_OUT-1:0] rstOut;
    logic             readyOut;
    logic             lockLost;
    logic [7:0]       retryCnt;

    int      checks = 0;
    int      errors = 0;
    outVec_t expQ[$];

    // Reference model state, all in terms of edge timestamps.
    int mode         = M_PLLRST;
    int curEdge      = 0;
    int pllRstStart  = 0;
    int waitStart    = 0;
    int releaseStart = 0;
    int lockRun      = 0;
    int mRetry       = 0;
    bit mLockLost    = 1'b0;
    bit syncA        = 1'b0;
    bit syncB        = 1'b0;

    crg_reset_seq #(
        .N_OUT        (N_OUT),
        .LOCK_FILT    (LOCK_FILT),
        .STAGE_GAP    (STAGE_GAP),
        .PLL_RST_LEN  (PLL_RST_LEN),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pll_locked (pllLocked),
        .sw_reset   (swReset),
        .pll_reset  (pllReset),
        .rst_out    (rstOut),
        .ready      (readyOut),
        .lock_lost  (lockLost),
        .retry_cnt  (retryCnt)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic outVec_t dutVec();
        return outVec_t'({pllReset, rstOut, readyOut, lockLost, retryCnt});
    endfunction

    function automatic outVec_t makeVec(input bit p, input logic [N_OUT-1:0] r,
                                        input bit rd, input bit ll, input int rt);
        outVec_t v;
        v.pllReset = p;
        v.rstOut   = r;
        v.ready    = rd;
        v.lockLost = ll;
        v.retry    = 8'(rt);
        return v;
    endfunction

    function automatic outVec_t resetVec();
        return makeVec(1'b1, '1, 1'b0, 1'b0, 0);
    endfunction

    // Domains released so far: bit 0 at releaseStart, one more every STAGE_GAP.
    function automatic int modelReleased();
        int n;
        n = 0;
        if (mode == M_RELEASED) begin
            n = 1 + (curEdge - releaseStart) / STAGE_GAP;
            if (n > N_OUT) n = N_OUT;
        end
        return n;
    endfunction

    function automatic outVec_t modelOut();
        logic [N_OUT-1:0] mask;
        int               n;
        n    = modelReleased();
        mask = '1;
        mask = mask << n;
        return makeVec(mode == M_PLLRST, mask, n == N_OUT, mLockLost, mRetry);
    endfunction

    task automatic enterAcquire();
        mode      = M_ACQUIRE;
        waitStart = curEdge;
        lockRun   = 0;
    endtask

    // One clock edge of the reference behaviour.
    task automatic modelStep(input bit locked, input bit swr, input bit rstIn);
        bit lockedS;
        curEdge++;
        if (rstIn) begin
            mode        = M_PLLRST;
            pllRstStart = curEdge;
            syncA       = 1'b0;
            syncB       = 1'b0;
            lockRun     = 0;
            mRetry      = 0;
            mLockLost   = 1'b0;
            return;
        end
        // Lock as seen by the sequencer lags the pin by two edges.
        lockedS = syncB;
        syncB   = syncA;
        syncA   = locked;
        if (swr) begin
            mode        = M_PLLRST;
            pllRstStart = curEdge;
            mRetry      = 0;
            mLockLost   = 1'b0;
            return;
        end
        case (mode)
            M_PLLRST: begin
                if (curEdge - pllRstStart == PLL_RST_LEN) enterAcquire();
            end
            M_ACQUIRE: begin
                if (lockedS) begin
                    lockRun++;
                    if (lockRun == LOCK_FILT) begin
                        mode         = M_RELEASED;
                        releaseStart = curEdge;
                    end
                end else if (lockRun > 0) begin
                    lockRun   = 0;
                    waitStart = curEdge;
                end else if (curEdge - waitStart == LOCK_TIMEOUT) begin
                    if (mRetry < 255) mRetry++;
                    mode        = M_PLLRST;
                    pllRstStart = curEdge;
                end
            end
            default: begin
                if (!lockedS) begin
                    mLockLost = 1'b1;
                    enterAcquire();
                end
            end
        endcase
    endtask

    task automatic applyStimulus(input bit locked, input bit swr, input bit rstIn);
        @(negedge clk);
        pllLocked = locked;
        swReset   = swr;
        reset     = rstIn;
        modelStep(locked, swr, rstIn);
        expQ.push_back(modelOut());
    endtask

    task automatic checkOutput(input string name, input outVec_t act, input outVec_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got pll_reset=%b rst_out=%b ready=%b lock_lost=%b retry=%0d, expected pll_reset=%b rst_out=%b ready=%b lock_lost=%b retry=%0d",
                     name, $time, act.pllReset, act.rstOut, act.ready, act.lockLost, act.retry,
                     exp.pllReset, exp.rstOut, exp.ready, exp.lockLost, exp.retry);
        end
    endtask

    task automatic checkValue(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic runUntilReleased(input int target, input string name);
        for (int i = 0; i < 200 && modelReleased() < target; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
        end
        if (modelReleased() < target) begin
            errors++;
            $display("[TB] FAIL %s: release stage %0d not reached", name, target);
        end
    endtask

    // Monitor: one expected entry per clock edge, sampled just after it.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                checkOutput("scoreboard", dutVec(), expQ.pop_front());
            end
        end
    end

    initial begin
        int dropLeft;
        bit lk;
        bit sw;

        reset     = 1'b0;
        pllLocked = 1'b1;
        swReset   = 1'b0;
        #1 reset  = 1'b1;
        #1 checkOutput("reset state", dutVec(), resetVec());

        $display("[TB] clean bring-up");
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b1);
        repeat (40) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("bring-up ready", dutVec(), makeVec(1'b0, '0, 1'b1, 1'b0, 0));

        $display("[TB] lock glitch during filter");
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (17) applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (40) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("glitch then ready", dutVec(), makeVec(1'b0, '0, 1'b1, 1'b0, 0));

        $display("[TB] lock loss in run");
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("lock loss", dutVec(), makeVec(1'b0, '1, 1'b0, 1'b1, 0));
        repeat (60) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("relock keeps lock_lost", dutVec(), makeVec(1'b0, '0, 1'b1, 1'b1, 0));

        $display("[TB] sw_reset during release");
        applyStimulus(1'b1, 1'b1, 1'b0);
        runUntilReleased(2, "sw_reset setup");
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("sw_reset mid-release", dutVec(), makeVec(1'b1, '1, 1'b0, 1'b0, 0));
        repeat (50) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("sw_reset then ready", dutVec(), makeVec(1'b0, '0, 1'b1, 1'b0, 0));

        $display("[TB] no lock, retry saturation");
        repeat (257 * (LOCK_TIMEOUT + PLL_RST_LEN)) applyStimulus(1'b0, 1'b0, 1'b0);
        checkValue("retry saturated", int'(retryCnt), 255);
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0);
        checkValue("sw_reset clears retry", int'(retryCnt), 0);
        checkValue("sw_reset holds pll_reset", int'(pllReset), 1);

        $display("[TB] async reset mid-release");
        runUntilReleased(2, "async reset setup");
        @(posedge clk);
        #2 reset = 1'b1;
        #1 checkOutput("async reset mid-release", dutVec(), resetVec());
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b1);
        repeat (50) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("restart after async reset", dutVec(), makeVec(1'b0, '0, 1'b1, 1'b0, 0));

        $display("[TB] random phase");
        dropLeft = 0;
        for (int i = 0; i < 2000; i++) begin
            if (dropLeft == 0 && $urandom_range(0, 399) == 0) begin
                dropLeft = $urandom_range(1, 120);
            end
            if (dropLeft > 0) begin
                lk = 1'b0;
                dropLeft--;
            end else begin
                lk = ($urandom_range(0, 99) >= 4);
            end
            sw = ($urandom_range(0, 499) == 0);
            applyStimulus(lk, sw, 1'b0);
        end

        for (int i = 0; i < 5 && expQ.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (expQ.size() > 0) begin
            errors++;
            $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", expQ.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
